// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down modulo counter family.
// Saturating behaviour is selected in the top with COUNTER_MOD_SATURATE_EN.
package counter_pkg;

   localparam int DEFAULT_WIDTH    = 4;
   localparam int DEFAULT_MODULO   = 16;
   localparam int DEFAULT_PRESCALE = 1;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   // Clamp a load value into 0..modulo-1; modulo is 33 bits so 2^32 is representable.
   function automatic logic [31:0] clamp_load(input logic [31:0] value,
                                              input logic [32:0] modulo);
      logic [32:0] max_val;
      max_val = modulo - 33'd1;
      return ({1'b0, value} > max_val) ? max_val[31:0] : value;
   endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the count enable: emits one tick per PRESCALE enabled cycles.
// With PRESCALE=1 the tick is the enable itself and no register exists.
module tick_prescaler #(
   parameter int PRESCALE = 1
) (
   input  logic clk,
   input  logic rst_i,
   input  logic en_i,
   input  logic restart_i,
   output logic tick_o
);

   generate
      if (PRESCALE == 1) begin : g_bypass
         logic unused_ok;
         assign unused_ok = ^{clk, rst_i, restart_i};
         assign tick_o    = en_i;
      end else begin : g_count
         localparam int              CW   = $clog2(PRESCALE);
         localparam logic [CW-1:0]   LAST = CW'(PRESCALE - 1);

         logic [CW-1:0] pre_cnt;

         // NOTE: sequential state uses non-blocking assignments so every register
         // samples pre-edge values regardless of block evaluation order.
         always_ff @(posedge clk or negedge rst_i) begin
            if (!rst_i) begin
               pre_cnt <= '0;
            end else if (restart_i) begin
               pre_cnt <= '0;
            end else if (en_i) begin
               pre_cnt <= (pre_cnt == LAST) ? '0 : pre_cnt + CW'(1);
            end
         end

         assign tick_o = en_i && (pre_cnt == LAST);
      end
   endgenerate

endmodule

// File: rtl/counter_mod_updown.sv
// Up/down modulo counter with load, clear, prescaled enable, tc decode and wrap pulse.
// Define COUNTER_MOD_SATURATE_EN to saturate at the limits instead of wrapping.
module counter_mod_updown
   import counter_pkg::*;
#(
   parameter int     WIDTH    = DEFAULT_WIDTH,
   parameter longint MODULO   = DEFAULT_MODULO,
   parameter int     PRESCALE = DEFAULT_PRESCALE
) (
   input  logic             clk,
   input  logic             rst_i,
   input  logic             en_i,
   input  logic             up_i,
   input  logic             clr_i,
   input  logic             load_i,
   input  logic [WIDTH-1:0] load_val_i,
   output logic [WIDTH-1:0] q_o,
   output logic             tc_o,
   output logic             wrap_o
);

   localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULO - 1);

   logic             tick;
   logic             at_max;
   logic             at_min;
   logic [WIDTH-1:0] load_clamped;

   assign at_max       = (q_o == Q_MAX);
   assign at_min       = (q_o == '0);
   assign load_clamped = WIDTH'(clamp_load(32'(load_val_i), 33'(MODULO)));

   tick_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk       (clk),
      .rst_i     (rst_i),
      .en_i      (en_i),
      .restart_i (clr_i | load_i),
      .tick_o    (tick)
   );

   // Priority: clear > load > tick > hold; a tick coinciding with clear/load is dropped.
   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         q_o    <= '0;
         wrap_o <= 1'b0;
      end else if (clr_i) begin
         q_o    <= '0;
         wrap_o <= 1'b0;
      end else if (load_i) begin
         q_o    <= load_clamped;
         wrap_o <= 1'b0;
      end else if (tick) begin
         if (up_i == DIR_UP) begin
            if (at_max) begin
`ifdef COUNTER_MOD_SATURATE_EN
               q_o    <= q_o;
`else
               q_o    <= '0;
`endif
               wrap_o <= 1'b1;
            end else begin
               q_o    <= q_o + WIDTH'(1);
               wrap_o <= 1'b0;
            end
         end else begin
            if (at_min) begin
`ifdef COUNTER_MOD_SATURATE_EN
               q_o    <= q_o;
`else
               q_o    <= Q_MAX;
`endif
               wrap_o <= 1'b1;
            end else begin
               q_o    <= q_o - WIDTH'(1);
               wrap_o <= 1'b0;
            end
         end
      end else begin
         wrap_o <= 1'b0;
      end
   end

   // Combinational decode; may glitch when up_i changes.
   assign tc_o = (up_i == DIR_UP) ? at_max : at_min;

endmodule

// File: tb/tb_counter_mod_updown.sv
// Scoreboard bench for counter_mod_updown: three parameter sets, expected values from a model.
module tb_counter_mod_updown;

   logic clk = 1'b0;
   logic rst_i;
   always #5 clk = ~clk;

   // DUT 0: defaults (W4, M16, P1); DUT 1: M10; DUT 2: PRESCALE=3
   logic       en_a, up_a, clr_a, load_a, tc_a, wrap_a;
   logic [3:0] lv_a, q_a;
   logic       en_b, up_b, clr_b, load_b, tc_b, wrap_b;
   logic [3:0] lv_b, q_b;
   logic       en_c, up_c, clr_c, load_c, tc_c, wrap_c;
   logic [3:0] lv_c, q_c;

   counter_mod_updown u_a (
      .clk(clk), .rst_i(rst_i), .en_i(en_a), .up_i(up_a), .clr_i(clr_a),
      .load_i(load_a), .load_val_i(lv_a), .q_o(q_a), .tc_o(tc_a), .wrap_o(wrap_a));

   counter_mod_updown #(.WIDTH(4), .MODULO(10), .PRESCALE(1)) u_b (
      .clk(clk), .rst_i(rst_i), .en_i(en_b), .up_i(up_b), .clr_i(clr_b),
      .load_i(load_b), .load_val_i(lv_b), .q_o(q_b), .tc_o(tc_b), .wrap_o(wrap_b));

   counter_mod_updown #(.WIDTH(4), .MODULO(16), .PRESCALE(3)) u_c (
      .clk(clk), .rst_i(rst_i), .en_i(en_c), .up_i(up_c), .clr_i(clr_c),
      .load_i(load_c), .load_val_i(lv_c), .q_o(q_c), .tc_o(tc_c), .wrap_o(wrap_c));

`ifdef COUNTER_MOD_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   localparam int MODS[3] = '{16, 10, 16};
   localparam int PRES[3] = '{1, 1, 3};

   typedef struct {
      int    dut;
      int    q;
      logic  wrap;
      string tag;
   } exp_t;

   exp_t sb[$];
   int   m_q[3];
   int   m_pre[3];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic logic [3:0] act_q(input int d);
      case (d)
         0:       return q_a;
         1:       return q_b;
         default: return q_c;
      endcase
   endfunction

   function automatic logic act_wrap(input int d);
      case (d)
         0:       return wrap_a;
         1:       return wrap_b;
         default: return wrap_c;
      endcase
   endfunction

   function automatic logic act_tc(input int d);
      case (d)
         0:       return tc_a;
         1:       return tc_b;
         default: return tc_c;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 3; i++) begin
         m_q[i]   = 0;
         m_pre[i] = 0;
      end
   endtask

   // Drive one cycle on DUT d (others idle), push model result, then pop and compare.
   task automatic drive(input int d, input logic en, input logic up, input logic clr,
                        input logic load, input logic [3:0] lv, input string tag);
      exp_t e, got;
      logic tick;
      en_a = 1'b0; clr_a = 1'b0; load_a = 1'b0;
      en_b = 1'b0; clr_b = 1'b0; load_b = 1'b0;
      en_c = 1'b0; clr_c = 1'b0; load_c = 1'b0;
      case (d)
         0:       begin en_a = en; up_a = up; clr_a = clr; load_a = load; lv_a = lv; end
         1:       begin en_b = en; up_b = up; clr_b = clr; load_b = load; lv_b = lv; end
         default: begin en_c = en; up_c = up; clr_c = clr; load_c = load; lv_c = lv; end
      endcase
      tick   = en && (m_pre[d] == PRES[d] - 1);
      e.dut  = d;
      e.tag  = tag;
      e.wrap = 1'b0;
      if (clr) begin
         m_q[d] = 0; m_pre[d] = 0;
      end else if (load) begin
         m_q[d] = (int'(lv) >= MODS[d]) ? MODS[d] - 1 : int'(lv);
         m_pre[d] = 0;
      end else begin
         if (en) m_pre[d] = (m_pre[d] == PRES[d] - 1) ? 0 : m_pre[d] + 1;
         if (tick) begin
            if (up) begin
               if (m_q[d] == MODS[d] - 1) begin
                  if (!SAT) m_q[d] = 0;
                  e.wrap = 1'b1;
               end else m_q[d] = m_q[d] + 1;
            end else begin
               if (m_q[d] == 0) begin
                  if (!SAT) m_q[d] = MODS[d] - 1;
                  e.wrap = 1'b1;
               end else m_q[d] = m_q[d] - 1;
            end
         end
      end
      e.q = m_q[d];
      sb.push_back(e);
      @(posedge clk);
      #1;
      got = sb.pop_front();
      n_cmp++;
      if (int'(act_q(got.dut)) !== got.q || act_wrap(got.dut) !== got.wrap) begin
         n_bad++;
         $display("FAIL %s: dut%0d q=%0d wrap=%0b, expected q=%0d wrap=%0b",
                  got.tag, got.dut, act_q(got.dut), act_wrap(got.dut), got.q, got.wrap);
      end
   endtask

   task automatic test_reset();
      rst_i = 1'b0;
      up_a = 1'b1; up_b = 1'b1; up_c = 1'b1;
      lv_a = '0; lv_b = '0; lv_c = '0;
      clr_a = 1'b0; clr_b = 1'b0; clr_c = 1'b0;
      load_a = 1'b0; load_b = 1'b0; load_c = 1'b0;
      en_a = 1'b1; en_b = 1'b0; en_c = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_cmp++;
      if (q_a !== 4'd0 || wrap_a !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_hold: q=%0d wrap=%0b, expected q=0 wrap=0", q_a, wrap_a);
      end
      rst_i = 1'b1;
      for (int i = 0; i < 17; i++) drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "count_up");
      for (int i = 0; i < 8; i++) drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "count_to_9");
      rst_i = 1'b0;
      #2;
      n_cmp++;
      if (q_a !== 4'd0 || wrap_a !== 1'b0) begin
         n_bad++;
         $display("FAIL async_reset: q=%0d wrap=%0b, expected q=0 wrap=0", q_a, wrap_a);
      end
      model_reset();
      en_a = 1'b0;
      @(posedge clk);
      #1;
      rst_i = 1'b1;
   endtask

   task automatic check_tc(input int d, input logic up, input string tag);
      logic exp_tc;
      exp_tc = up ? (m_q[d] == MODS[d] - 1) : (m_q[d] == 0);
      case (d)
         0:       up_a = up;
         1:       up_b = up;
         default: up_c = up;
      endcase
      #1;
      n_cmp++;
      if (act_tc(d) !== exp_tc) begin
         n_bad++;
         $display("FAIL %s: tc=%0b, expected %0b", tag, act_tc(d), exp_tc);
      end
   endtask

   task automatic test_down_mod10();
      check_tc(1, 1'b0, "tc_down_at_0");
      check_tc(1, 1'b1, "tc_up_at_0");
      drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "down_wrap");
      check_tc(1, 1'b1, "tc_up_at_9");
      for (int i = 0; i < 3; i++) drive(1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "down_step");
      for (int i = 0; i < 4; i++) drive(1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "up_wrap_m10");
   endtask

   task automatic test_prescale();
      logic en_seq[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 4; i++) drive(2, en_seq[i], 1'b1, 1'b0, 1'b0, 4'd0, "prescale3");
      for (int i = 0; i < 3; i++) drive(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "prescale3_b");
   endtask

   task automatic test_priority();
      drive(1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd12, "load_clamp");
      drive(1, 1'b1, 1'b1, 1'b1, 1'b1, 4'd5,  "clr_over_load");
      drive(1, 1'b1, 1'b1, 1'b0, 1'b1, 4'd7,  "load_in_range");
      drive(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  "pre_ph1");
      drive(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  "pre_ph2");
      drive(2, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5,  "load_on_tick");
      for (int i = 0; i < 3; i++) drive(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "after_load");
      drive(2, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  "clr_prescaled");
   endtask

   task automatic test_limits();
      drive(0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd14, "load_14");
      for (int i = 0; i < 3; i++) drive(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, "limit_up");
      drive(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, "load_1");
      for (int i = 0; i < 3; i++) drive(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, "limit_down");
      drive(0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, "idle_wrap_low");
   endtask

   initial begin
      test_reset();
      test_down_mod10();
      test_prescale();
      test_priority();
      test_limits();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
